// File: rtl/rv32i_pipe_pkg.sv
// rv32i_pipe_pkg: shared types and constants for the RV32I pipeline control
package rv32i_pipe_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} memState_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  // M-stage result is younger than W, so it takes priority; x0 never forwards
  function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdM,
                                        input logic [4:0] rdW, input logic regWriteM,
                                        input logic regWriteW);
    return (regWriteM && rdM != 5'd0 && rdM == rs) ? FWD_M :
           (regWriteW && rdW != 5'd0 && rdW == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/dmem_wait_fsm.sv
// dmem_wait_fsm: data-memory wait-state handshake with access timeout
import rv32i_pipe_pkg::*;
module dmem_wait_fsm #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic frozen,
  output logic bus_error
);
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(MAX_WAIT - 1);
  memState_t state, stateNext;
  logic [WCNT_W-1:0] wcnt, wcntNext;
  logic errNext;
  assign frozen = state != IDLE;
  // state, wait counter and sticky error register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= stateNext;
      wcnt <= wcntNext;
      bus_error <= errNext;
    end
  end
  // next state and request; ERR is only left through reset
  always_comb begin
    stateNext = state;
    wcntNext = wcnt;
    errNext = bus_error;
    dmem_req = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = MemReqM;
        if (MemReqM && !dmem_ready) begin
          stateNext = WAIT;
          wcntNext = '0;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) stateNext = IDLE;
        else if (wcnt == LAST) begin
          stateNext = ERR;
          errNext = 1'b1;
        end else wcntNext = wcnt + 1'b1;
      end
      default: ;
    endcase
    if (reset) dmem_req = 1'b0;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and forwarding control for the 5-stage RV32I pipeline
import rv32i_pipe_pkg::*;
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic MemReadE,
  input  logic PCSrcE,
  input  logic RegWriteM,
  input  logic RegWriteW,
  input  logic MemReqM,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic bus_error,
  output logic [CNT_W-1:0] stall_count
);
  logic frozen, loadUse, run;
  dmem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) memFsm (
    .clk(clk),
    .reset(reset),
    .MemReqM(MemReqM),
    .dmem_ready(dmem_ready),
    .dmem_req(dmem_req),
    .frozen(frozen),
    .bus_error(bus_error)
  );
  assign ForwardAE = fwdSel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign ForwardBE = fwdSel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  assign loadUse = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign run = !reset && !frozen;
  // memory freeze beats branch, branch beats load-use; everything off in reset
  always_comb begin
    StallF = !reset && (frozen || (loadUse && !PCSrcE));
    StallD = StallF;
    StallE = !reset && frozen;
    StallM = StallE;
    FlushD = run && PCSrcE;
    FlushE = run && (PCSrcE || loadUse);
    FlushW = StallE;
  end
  // saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count <= '0;
    else if ((StallF || StallM) && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic MemReadE = 0, PCSrcE = 0, RegWriteM = 0, RegWriteW = 0, MemReqM = 0, dmem_ready = 0;
  logic dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, bus_error;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_count;
  int checks = 0, errors = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .bus_error(bus_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packs {dmem_req,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [15:0] ctl();
    return {8'd0, dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("reset_ctl", ctl(), 16'h00);
    MemReqM = 1; PCSrcE = 1; MemReadE = 1; RdE = 3; Rs1D = 3;
    #1;
    chk("reset_forced_ctl", ctl(), 16'h00);
    MemReqM = 0; PCSrcE = 0; MemReadE = 0; RdE = 0; Rs1D = 0;
    tick();
    chk("reset_cnt", stall_count, 0);
    chk("reset_berr", bus_error, 0);
    reset = 0;
    tick();
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    #1;
    chk("fwdA_M", ForwardAE, 2'b10);
    chk("fwdB_rf", ForwardBE, 2'b00);
    RdM = 0; Rs2E = 5;
    #1;
    chk("fwdA_W", ForwardAE, 2'b01);
    chk("fwdB_W", ForwardBE, 2'b01);
    RegWriteW = 0;
    #1;
    chk("fwdB_noWrite", ForwardBE, 2'b00);
    RegWriteW = 1; Rs1E = 0;
    #1;
    chk("fwdA_x0", ForwardAE, 2'b00);
    RegWriteM = 0; RegWriteW = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    MemReadE = 1; RdE = 7; Rs2D = 7;
    #1;
    chk("lu_ctl", ctl(), 16'b0110_0010);
    tick();
    MemReadE = 0; RdE = 0; Rs2D = 0;
    #1;
    chk("lu_release", ctl(), 16'h00);
    chk("lu_cnt", stall_count, 1);
    MemReadE = 1; RdE = 0; Rs1D = 0;
    #1;
    chk("lu_x0", ctl(), 16'h00);
    RdE = 7; Rs1D = 7; PCSrcE = 1;
    #1;
    chk("br_over_lu", ctl(), 16'b0000_0110);
    tick();
    chk("br_cnt", stall_count, 1);
    MemReadE = 0; RdE = 0; Rs1D = 0; PCSrcE = 0;
    MemReqM = 1;
    #1;
    chk("mem_req_c0", ctl(), 16'b1000_0000);
    tick();
    PCSrcE = 1;
    #1;
    chk("mem_wait_c1", ctl(), 16'b1111_1001);
    tick();
    chk("mem_wait_c2", ctl(), 16'b1111_1001);
    tick();
    dmem_ready = 1;
    #1;
    chk("mem_wait_c3", ctl(), 16'b1111_1001);
    tick();
    MemReqM = 0; dmem_ready = 0;
    #1;
    chk("mem_released_br", ctl(), 16'b0000_0110);
    chk("mem_cnt", stall_count, 4);
    PCSrcE = 0; MemReqM = 1; dmem_ready = 1;
    #1;
    chk("mem_zero_wait", ctl(), 16'b1000_0000);
    tick();
    chk("mem_zero_wait_next", ctl(), 16'b1000_0000);
    chk("mem_zero_cnt", stall_count, 4);
    dmem_ready = 0;
    tick();
    tick();
    tick();
    tick();
    chk("to_last_wait", ctl(), 16'b1111_1001);
    chk("to_no_err_yet", bus_error, 0);
    tick();
    chk("to_berr", bus_error, 1);
    chk("to_err_ctl", ctl(), 16'b0111_1001);
    chk("to_cnt", stall_count, 8);
    dmem_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("err_sticky_ctl", ctl(), 16'b0111_1001);
    chk("err_sticky_berr", bus_error, 1);
    chk("cnt_saturate", stall_count, 15);
    reset = 1;
    #1;
    chk("err_reset_ctl", ctl(), 16'h00);
    chk("err_reset_berr", bus_error, 0);
    chk("err_reset_cnt", stall_count, 0);
    reset = 0; dmem_ready = 0;
    tick();
    tick();
    chk("midwait_stall", ctl(), 16'b1111_1001);
    #2 reset = 1;
    #1;
    chk("midwait_reset_ctl", ctl(), 16'h00);
    MemReqM = 0;
    #1 reset = 0;
    #1;
    chk("post_reset_idle", ctl(), 16'h00);
    tick();
    chk("post_reset_ctl", ctl(), 16'h00);
    chk("post_reset_cnt", stall_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
